instr_fetch: RTL and testbench

Instruction fetch stage of the single-cycle MIPS datapath, directly upstream of the control unit.
- Holds the program counter and issues requests to instruction memory with a ready handshake.
- Latches the returned word into an instruction register and presents its opcode field to the control unit.
- Computes the next PC from the control unit's branch/jump signals and the ALU zero flag.
- Stalls on a hold request.

---
 rtl/mips_pkg.sv | 25 ++
 rtl/instr_fetch_if.sv | 33 +++
 rtl/instr_fetch_next_pc_logic.sv | 50 +++++
 rtl/instr_fetch.sv | 139 +++++++++++++
 tb/tb_instr_fetch.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared types and constants for the MIPS fetch stage.
//                Holds the fetch FSM state type, instruction field positions
//                and the default reset PC.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2
    } fetch_state_t;

    localparam int OPCODE_MSB  = 31;
    localparam int OPCODE_LSB  = 26;
    localparam int IMM_WIDTH   = 16;
    localparam int JADDR_WIDTH = 26;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage
`default_nettype wire

// File: rtl/instr_fetch_if.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_if
//  Description : Instruction memory request/ready bus. The fetch stage is the
//                master (drives address and request), the memory is the slave
//                (returns data and ready in the same cycle).
//  Revision    : 1.0 - initial release
// ============================================================================
interface instr_fetch_if #(
    parameter int PC_WIDTH = 32
) ();

    logic [PC_WIDTH-1:0] imem_addr;
    logic                imem_req;
    logic [31:0]         imem_rdata;
    logic                imem_ready;

    modport master (
        output imem_addr,
        output imem_req,
        input  imem_rdata,
        input  imem_ready
    );

    modport slave (
        input  imem_addr,
        input  imem_req,
        output imem_rdata,
        output imem_ready
    );

endinterface
`default_nettype wire

// File: rtl/instr_fetch_next_pc_logic.sv
`default_nettype none
// ============================================================================
//  Module      : next_pc_logic
//  Description : Combinational next-PC selection. Jump has priority over a
//                taken branch, otherwise sequential pc+4. All adds wrap
//                modulo 2^PC_WIDTH.
//  Revision    : 1.0 - initial release
// ============================================================================
module next_pc_logic
    import mips_pkg::*;
#(
    parameter int PC_WIDTH = 32
) (
    input  wire logic [PC_WIDTH-1:0] pc_plus4,
    input  wire logic [31:0]         instr,
    input  wire logic                sign_branch,
    input  wire logic                sign_jump,
    input  wire logic                alu_zero,
    output logic      [PC_WIDTH-1:0] next_pc
);

    logic [PC_WIDTH-1:0] w_jump_target;
    logic [PC_WIDTH-1:0] w_branch_offset;
    logic [PC_WIDTH-1:0] w_branch_target;

    // The opcode field plays no part in target computation.
    logic w_unused_opcode;
    assign w_unused_opcode = &{1'b0, instr[31:JADDR_WIDTH]};

    // Jump keeps the upper region bits of pc+4 and replaces the rest.
    assign w_jump_target   = {pc_plus4[PC_WIDTH-1:JADDR_WIDTH+2],
                              instr[JADDR_WIDTH-1:0], 2'b00};

    // Word offset, sign-extended to the PC width; wraps naturally.
    assign w_branch_offset = {{(PC_WIDTH-IMM_WIDTH-2){instr[IMM_WIDTH-1]}},
                              instr[IMM_WIDTH-1:0], 2'b00};
    assign w_branch_target = pc_plus4 + w_branch_offset;

    // Priority select: jump, then taken branch, then sequential.
    always_comb begin
        next_pc = pc_plus4;
        if (sign_jump) begin
            next_pc = w_jump_target;
        end else if (sign_branch && alu_zero) begin
            next_pc = w_branch_target;
        end
    end

endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch
//  Description : MIPS instruction fetch stage. Holds the PC, fetches over a
//                request/ready bus into an instruction register, presents the
//                opcode to control, and advances the PC from branch/jump
//                controls unless stalled.
//                Optional macro IFETCH_INSTR_COUNT_EN adds a 32-bit count of
//                fetched instructions on output instr_count.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch
    import mips_pkg::*;
#(
    parameter int                PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = PC_WIDTH'(DEFAULT_RESET_PC)
) (
    input  wire logic                clk,
    input  wire logic                rst_n,
    instr_fetch_if.master            imem,
    input  wire logic                sign_branch,
    input  wire logic                sign_jump,
    input  wire logic                alu_zero,
    input  wire logic                stall,
    output logic      [PC_WIDTH-1:0] pc,
    output logic      [PC_WIDTH-1:0] pc_plus4,
    output logic      [31:0]         instr,
    output logic      [5:0]          op_code,
    output logic                     instr_valid
`ifdef IFETCH_INSTR_COUNT_EN
    ,
    output logic      [31:0]         instr_count
`endif
);

    fetch_state_t        r_state;
    fetch_state_t        w_state_nxt;
    logic [PC_WIDTH-1:0] r_pc;
    logic [31:0]         r_instr;
    logic [PC_WIDTH-1:0] w_pc_plus4;
    logic [PC_WIDTH-1:0] w_next_pc;
    logic                w_load_instr;
    logic                w_advance_pc;
    logic                w_req;
    logic                w_valid;

    assign w_pc_plus4 = r_pc + PC_WIDTH'(4);

    next_pc_logic #(
        .PC_WIDTH (PC_WIDTH)
    ) u_next_pc_logic (
        .pc_plus4    (w_pc_plus4),
        .instr       (r_instr),
        .sign_branch (sign_branch),
        .sign_jump   (sign_jump),
        .alu_zero    (alu_zero),
        .next_pc     (w_next_pc)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and per-state strobes; control inputs matter only where used.
    always_comb begin
        w_state_nxt  = r_state;
        w_load_instr = 1'b0;
        w_advance_pc = 1'b0;
        w_req        = 1'b0;
        w_valid      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_FETCH;
            end
            S_FETCH: begin
                w_req = 1'b1;
                if (imem.imem_ready) begin
                    w_load_instr = 1'b1;
                    w_state_nxt  = S_EXEC;
                end
            end
            S_EXEC: begin
                w_valid = 1'b1;
                if (!stall) begin
                    w_advance_pc = 1'b1;
                    w_state_nxt  = S_FETCH;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // PC and instruction register; reset drops any pending load or update.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc    <= RESET_PC;
            r_instr <= 32'h0;
        end else begin
            if (w_load_instr) begin
                r_instr <= imem.imem_rdata;
            end
            if (w_advance_pc) begin
                r_pc <= w_next_pc;
            end
        end
    end

`ifdef IFETCH_INSTR_COUNT_EN
    logic [31:0] r_instr_count;

    // Count each completed fetch; wraps at 2^32.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_instr_count <= 32'h0;
        end else if (w_load_instr) begin
            r_instr_count <= r_instr_count + 32'd1;
        end
    end

    assign instr_count = r_instr_count;
`endif

    assign imem.imem_addr = r_pc;
    assign imem.imem_req  = w_req;
    assign pc             = r_pc;
    assign pc_plus4       = w_pc_plus4;
    assign instr          = r_instr;
    assign op_code        = r_instr[OPCODE_MSB:OPCODE_LSB];
    assign instr_valid    = w_valid;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_fetch
//  Description : Self-checking bench for instr_fetch: directed scenarios with
//                literal expectations, then randomized traffic compared every
//                cycle against a behavioural reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

    localparam logic [31:0] C_RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst_n;
    logic        sign_branch;
    logic        sign_jump;
    logic        alu_zero;
    logic        stall;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instr;
    logic [5:0]  op_code;
    logic        instr_valid;
`ifdef IFETCH_INSTR_COUNT_EN
    logic [31:0] instr_count;
`endif

    instr_fetch_if #(.PC_WIDTH(32)) u_if ();

    instr_fetch #(
        .PC_WIDTH (32),
        .RESET_PC (C_RESET_PC)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem        (u_if),
        .sign_branch (sign_branch),
        .sign_jump   (sign_jump),
        .alu_zero    (alu_zero),
        .stall       (stall),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .instr       (instr),
        .op_code     (op_code),
        .instr_valid (instr_valid)
`ifdef IFETCH_INSTR_COUNT_EN
        ,
        .instr_count (instr_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what the stage holds, from the behavioural rules.
    logic        m_live    = 1'b0;  // a reset has been seen
    logic        m_booting = 1'b0;  // one dead cycle after reset
    logic        m_holding = 1'b0;  // an instruction is held for execution
    logic [31:0] m_pc      = 32'h0;
    logic [31:0] m_instr   = 32'h0;
    logic [31:0] m_cnt     = 32'h0;

    function automatic logic [31:0] f_target(input logic [31:0] cur_pc, input logic [31:0] word,
                                             input logic br, input logic jmp, input logic zero);
        logic [31:0] seq;
        int          offs;
        seq  = cur_pc + 32'd4;
        offs = int'($signed(word[15:0])) * 4;
        if (jmp)
            return (seq & 32'hF000_0000) | ((word & 32'h03FF_FFFF) << 2);
        if (br && zero)
            return seq + 32'(offs);
        return seq;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_live    = 1'b1;
            m_booting = 1'b1;
            m_holding = 1'b0;
            m_pc      = C_RESET_PC;
            m_instr   = 32'h0;
            m_cnt     = 32'h0;
        end else if (m_booting) begin
            m_booting = 1'b0;
        end else if (!m_holding) begin
            if (u_if.imem_ready) begin
                m_instr   = u_if.imem_rdata;
                m_holding = 1'b1;
                m_cnt     = m_cnt + 32'd1;
            end
        end else if (!stall) begin
            m_pc      = f_target(m_pc, m_instr, sign_branch, sign_jump, alu_zero);
            m_holding = 1'b0;
        end
    end

    // Compare every output against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_live) begin
            chk("imem_req",    {31'h0, u_if.imem_req}, {31'h0, (!m_booting && !m_holding)});
            chk("imem_addr",   u_if.imem_addr, m_pc);
            chk("pc",          pc, m_pc);
            chk("pc_plus4",    pc_plus4, m_pc + 32'd4);
            chk("instr",       instr, m_instr);
            chk("op_code",     {26'h0, op_code}, {26'h0, m_instr[31:26]});
            chk("instr_valid", {31'h0, instr_valid}, {31'h0, m_holding});
`ifdef IFETCH_INSTR_COUNT_EN
            chk("instr_count", instr_count, m_cnt);
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Present one instruction word with ready, then execute it with controls.
    task automatic fetch_exec(input logic [31:0] word, input logic br, input logic jmp,
                              input logic zero);
        u_if.imem_rdata  = word;
        u_if.imem_ready  = 1'b1;
        step();
        u_if.imem_ready  = 1'b0;
        sign_branch      = br;
        sign_jump        = jmp;
        alu_zero         = zero;
        step();
        sign_branch      = 1'b0;
        sign_jump        = 1'b0;
        alu_zero         = 1'b0;
    endtask

    initial begin
        rst_n           = 1'b0;
        sign_branch     = 1'b0;
        sign_jump       = 1'b0;
        alu_zero        = 1'b0;
        stall           = 1'b0;
        u_if.imem_rdata = 32'h0;
        u_if.imem_ready = 1'b0;

        // Reset state.
        step();
        step();
        chk("rst_pc",    pc, 32'h0);
        chk("rst_req",   {31'h0, u_if.imem_req}, 32'h0);
        chk("rst_valid", {31'h0, instr_valid}, 32'h0);
        chk("rst_instr", instr, 32'h0);

        // Release: dead cycle, then the first request at address 0.
        rst_n = 1'b1;
        step();
        chk("first_req",  {31'h0, u_if.imem_req}, 32'h1);
        chk("first_addr", u_if.imem_addr, 32'h0);

        // Zero-wait fetch of 0x20080005.
        u_if.imem_rdata = 32'h2008_0005;
        u_if.imem_ready = 1'b1;
        step();
        u_if.imem_ready = 1'b0;
        chk("first_op",    {26'h0, op_code}, 32'h08);
        chk("first_valid", {31'h0, instr_valid}, 32'h1);
        step();
        chk("seq_pc", pc, 32'h4);
`ifdef IFETCH_INSTR_COUNT_EN
        chk("cnt_one", instr_count, 32'h1);
`endif

        // Jump into 0x00400000, then jump from there to 0x40.
        fetch_exec(32'h0810_0000, 1'b0, 1'b1, 1'b0);
        chk("jmp_setup", pc, 32'h0040_0000);
        fetch_exec(32'h0800_0010, 1'b0, 1'b1, 1'b0);
        chk("jmp_target", u_if.imem_addr, 32'h0000_0040);

        // Reach 0x100, then branch with offset -1 taken and not taken.
        fetch_exec(32'h0800_0040, 1'b0, 1'b1, 1'b0);
        chk("br_setup", pc, 32'h0000_0100);
        fetch_exec(32'h1000_FFFF, 1'b1, 1'b0, 1'b1);
        chk("br_taken", u_if.imem_addr, 32'h0000_0100);
        fetch_exec(32'h1000_FFFF, 1'b1, 1'b0, 1'b0);
        chk("br_not_taken", u_if.imem_addr, 32'h0000_0104);

        // Three wait states: request and address held, instr untouched.
        for (int i = 0; i < 3; i++) begin
            step();
            chk("wait_req",   {31'h0, u_if.imem_req}, 32'h1);
            chk("wait_addr",  u_if.imem_addr, 32'h0000_0104);
            chk("wait_instr", instr, 32'h1000_FFFF);
        end

        // Negative branch from 0x104 wrapping to 0xFFFFFFFC.
        fetch_exec(32'h1000_FFBD, 1'b1, 1'b0, 1'b1);
        chk("br_wrap", pc, 32'hFFFF_FFFC);

        // Stall two cycles at the top of memory; a jump during stall is ignored.
        u_if.imem_rdata = 32'h0000_0020;
        u_if.imem_ready = 1'b1;
        step();
        u_if.imem_ready = 1'b0;
        stall           = 1'b1;
        sign_jump       = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("stall_pc",    pc, 32'hFFFF_FFFC);
            chk("stall_instr", instr, 32'h0000_0020);
        end
        stall     = 1'b0;
        sign_jump = 1'b0;
        step();
        chk("wrap_addr", u_if.imem_addr, 32'h0000_0000);
        chk("wrap_req",  {31'h0, u_if.imem_req}, 32'h1);

        // Reset in the middle of a pending fetch.
        rst_n = 1'b0;
        step();
        chk("midrst_req",   {31'h0, u_if.imem_req}, 32'h0);
        chk("midrst_pc",    pc, C_RESET_PC);
        chk("midrst_valid", {31'h0, instr_valid}, 32'h0);
`ifdef IFETCH_INSTR_COUNT_EN
        chk("midrst_cnt", instr_count, 32'h0);
`endif
        rst_n = 1'b1;
        step();

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            rst_n           = ($urandom_range(0, 99) != 0);
            u_if.imem_ready = ($urandom_range(0, 1) == 1);
            u_if.imem_rdata = $urandom;
            stall           = ($urandom_range(0, 2) == 0);
            sign_jump       = ($urandom_range(0, 3) == 0);
            sign_branch     = ($urandom_range(0, 1) == 1);
            alu_zero        = ($urandom_range(0, 1) == 1);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
